// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: RV32I load/store funct3 codes, fault codes and LSU state encoding.
package lsu_mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN   = 2'b01;
    localparam logic [1:0] FAULT_BUS     = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: req/gnt/rvalid data bus between the LSU (master) and memory (slave).
interface lsu_mem_stage_if #(parameter int ADDR_W = 32);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

endinterface

// File: rtl/lsu_mem_stage_align.sv
// lsu_mem_stage_align: byte enables, store lane replication, load extraction/extension
// and illegal/misaligned detection for one RV32I memory op.
module lsu_mem_stage_align
    import lsu_mem_stage_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] ldata,
    output logic        bad
);

    logic [31:0] shifted;
    logic        illegal;
    logic        misaligned;

    always_comb begin
        illegal    = is_store ? (funct3 > F3_W)
                              : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = (funct3[1:0] == 2'b10 && addr_lo != 2'b00) ||
                     (funct3[1:0] == 2'b01 && addr_lo[0]);
        bad        = illegal || misaligned;
        // loads always fetch the whole word; extraction happens on return
        be         = (!is_store || funct3[1:0] == 2'b10) ? 4'b1111 :
                     (funct3[1:0] == 2'b01) ? 4'b0011 << {addr_lo[1], 1'b0} :
                                              4'b0001 << addr_lo;
        wlane      = (funct3[1:0] == 2'b00) ? {4{wdata[7:0]}} :
                     (funct3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
        shifted    = rdata >> {addr_lo, 3'b000};
        ldata      = (funct3 == F3_B)  ? {{24{shifted[7]}}, shifted[7:0]} :
                     (funct3 == F3_H)  ? {{16{shifted[15]}}, shifted[15:0]} :
                     (funct3 == F3_BU) ? {24'b0, shifted[7:0]} :
                     (funct3 == F3_HU) ? {16'b0, shifted[15:0]} : rdata;
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I memory stage; runs one load/store over the req/gnt/rvalid bus
// per start, stalling the core via busy and reporting the result with a done pulse.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic [1:0]            fault,
    lsu_mem_stage_if.master       bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  fault_d;
    logic [31:0] load_d;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  alo_q;
    logic        accept;
    logic        expired;
    logic        a_st;
    logic [2:0]  a_f3;
    logic [1:0]  a_lo;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic [31:0] ldata;
    logic        bad;

    // decode the live op while idle, the latched op while it is in flight
    assign a_st = (state_q == S_IDLE) ? is_store   : st_q;
    assign a_f3 = (state_q == S_IDLE) ? funct3     : f3_q;
    assign a_lo = (state_q == S_IDLE) ? addr[1:0]  : alo_q;

    lsu_mem_stage_align u_align (
        .is_store (a_st),
        .funct3   (a_f3),
        .addr_lo  (a_lo),
        .wdata    (wdata),
        .rdata    (bus.mem_rdata),
        .be       (be),
        .wlane    (wlane),
        .ldata    (ldata),
        .bad      (bad)
    );

    assign accept      = (state_q == S_IDLE) && start;
    assign expired     = cnt_q >= CW'(TIMEOUT_CYCLES - 1);
    assign busy        = (state_q == S_REQ) || (state_q == S_WAIT);
    assign done        = (state_q == S_DONE);
    assign bus.mem_req = (state_q == S_REQ);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault;
        load_d  = load_data;
        case (state_q)
            S_IDLE: if (start) begin
                if (bad) begin
                    state_d = S_DONE;
                    fault_d = FAULT_ALIGN;
                    load_d  = is_store ? load_data : '0;
                end else begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ, S_WAIT: begin
                if (bus.mem_rvalid && (state_q == S_WAIT || bus.mem_gnt)) begin
                    state_d = S_DONE;
                    fault_d = bus.mem_err ? FAULT_BUS : FAULT_NONE;
                    load_d  = st_q ? load_data : (bus.mem_err ? '0 : ldata);
                end else if (state_q == S_REQ && bus.mem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end else if (expired) begin
                    state_d = S_DONE;
                    fault_d = FAULT_TIMEOUT;
                    load_d  = st_q ? load_data : '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            fault         <= FAULT_NONE;
            load_data     <= '0;
            st_q          <= 1'b0;
            f3_q          <= '0;
            alo_q         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fault     <= fault_d;
            load_data <= load_d;
            if (accept) begin
                st_q  <= is_store;
                f3_q  <= funct3;
                alo_q <= addr[1:0];
                if (!bad) begin
                    bus.mem_we    <= is_store;
                    bus.mem_addr  <= ADDR_W'({addr[31:2], 2'b00});
                    bus.mem_be    <= be;
                    bus.mem_wdata <= wlane;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: randomized scoreboard bench; expected bus requests and results are
// computed from the load/store rules and checked by independent bus and result monitors.
module tb_lsu_mem_stage;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  fault;

    lsu_mem_stage_if #(.ADDR_W(32)) bus ();

    lsu_mem_stage #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .load_data (load_data),
        .fault     (fault),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ld;
        logic [1:0]  f;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        int          cyc;
    } bus_t;

    res_t        res_q[$];
    bus_t        bus_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] model_ld = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] w = rd >> (8 * a[1:0]);
        case (f3)
            3'd0:    return 32'($signed(w[7:0]));
            3'd1:    return 32'($signed(w[15:0]));
            3'd4:    return {24'b0, w[7:0]};
            3'd5:    return {16'b0, w[15:0]};
            default: return rd;
        endcase
    endfunction

    // result monitor
    always @(negedge clk) begin : res_mon
        res_t r;
        if (rst_n && done) begin
            if (res_q.size() == 0) chk("unexpected_done", {31'b0, done}, 32'd0);
            else begin
                r = res_q.pop_front();
                chk("load_data", load_data, r.ld);
                chk("fault", {30'b0, fault}, {30'b0, r.f});
            end
        end
    end

    // bus monitor: checks request fields, their stability and the request duration
    int   run = 0;
    logic stable = 1'b1;
    logic req_flagged = 1'b0;
    bus_t cur;

    task automatic close_run();
        chk("req_cycles", run, cur.cyc);
        chk("req_stable", {31'b0, stable}, 32'd1);
        void'(bus_q.pop_front());
        run = 0;
        stable = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
            stable = 1'b1;
        end else if (bus.mem_req) begin
            if (bus_q.size() == 0) begin
                if (!req_flagged) chk("unexpected_req", 32'd1, 32'd0);
                req_flagged = 1'b1;
            end else begin
                if (run == 0) begin
                    cur = bus_q[0];
                    chk("mem_addr", bus.mem_addr, cur.a);
                    chk("mem_be", {28'b0, bus.mem_be}, {28'b0, cur.be});
                    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, cur.we});
                    if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wd);
                end else if (bus.mem_addr !== cur.a || bus.mem_be !== cur.be || bus.mem_we !== cur.we ||
                             (cur.we && bus.mem_wdata !== cur.wd)) stable = 1'b0;
                run++;
                if (bus.mem_gnt) close_run();
            end
        end else if (run > 0) close_run();
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // g: REQ cycle on which gnt is given (<0 never); r: cycles from gnt to rvalid (<0 never)
    task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input int g, input int r, input logic [31:0] rd, input logic er);
        bit   legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        int   size = 1 << f3[1:0];
        bit   ok = legal && (a % size == 0);
        res_t e;
        bus_t b;
        if (!ok) begin
            e.f = 2'b01;
            if (!st) model_ld = '0;
        end else begin
            b.a  = a & ~32'h3;
            b.we = st;
            b.be = (!st || size == 4) ? 4'hF : 4'(((size == 2) ? 3 : 1) << a[1:0]);
            b.wd = (size == 1) ? wd[7:0] * 32'h01010101 : (size == 2) ? wd[15:0] * 32'h00010001 : wd;
            b.cyc = (g < 0) ? T : g + 1;
            bus_q.push_back(b);
            if (g < 0 || r < 0 || g + r >= T) begin
                e.f = 2'b11;
                if (!st) model_ld = '0;
            end else if (er) begin
                e.f = 2'b10;
                if (!st) model_ld = '0;
            end else begin
                e.f = 2'b00;
                if (!st) model_ld = ext(f3, a, rd);
            end
        end
        e.ld = model_ld;
        res_q.push_back(e);
        @(negedge clk);
        is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        if (ok) begin
            for (int i = 0; i < T + 2; i++) begin
                bus.mem_gnt    = (i == g);
                bus.mem_rvalid = (g >= 0 && r >= 0 && i == g + r);
                bus.mem_rdata  = bus.mem_rvalid ? rd : $urandom;
                bus.mem_err    = bus.mem_rvalid ? er : 1'($urandom);
                @(negedge clk);
            end
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_be", {28'b0, bus.mem_be}, 32'd0);
        chk("rst_fault", {30'b0, fault}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;

        op(0, 3'd2, 32'h100, 32'h0, 1, 0, 32'hDEADBEEF, 0);
        op(0, 3'd0, 32'h103, 32'h0, 0, 1, 32'h80123456, 0);
        op(0, 3'd4, 32'h103, 32'h0, 0, 1, 32'h80123456, 0);
        op(1, 3'd1, 32'h202, 32'h1234ABCD, 0, 1, 32'h0, 0);
        op(0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0, 0);
        op(0, 3'd1, 32'h103, 32'h0, 0, 0, 32'h0, 0);
        op(0, 3'd3, 32'h104, 32'h0, 0, 0, 32'h0, 0);
        op(1, 3'd3, 32'h104, 32'h0, 0, 0, 32'h0, 0);
        op(0, 3'd2, 32'h400, 32'h0, -1, 0, 32'h0, 0);
        op(1, 3'd2, 32'h500, 32'h55AA55AA, 0, -1, 32'h0, 0);
        op(0, 3'd5, 32'h602, 32'h0, T - 1, 0, 32'h8001FFFF, 0);
        op(0, 3'd1, 32'h602, 32'h0, 2, 5, 32'h8001FFFF, 0);
        op(0, 3'd2, 32'h700, 32'h0, 2, 6, 32'h12345678, 0);

        // reset asserted while the load waits for its response
        bus_q.push_back('{a: 32'h300, be: 4'hF, wd: 32'h0, we: 1'b0, cyc: 1});
        @(negedge clk);
        is_store = 0; funct3 = 3'd2; addr = 32'h300; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        @(negedge clk);
        chk("wait_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_req", {31'b0, bus.mem_req}, 32'd0);
        chk("abort_load_data", load_data, 32'd0);
        model_ld = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_rvalid_busy", {31'b0, busy}, 32'd0);
        op(0, 3'd2, 32'h300, 32'h0, 0, 2, 32'hCAFEF00D, 0);
        op(0, 3'd2, 32'h304, 32'h0, 1, 1, 32'h11111111, 1);

        for (int k = 0; k < 200; k++) begin
            int g, r, mode;
            mode = $urandom_range(0, 7);
            case (mode)
                0:       begin g = -1; r = 0; end
                1:       begin g = $urandom_range(0, 3); r = -1; end
                2:       begin g = $urandom_range(0, T - 1); r = 0; end
                3:       begin g = $urandom_range(0, 3); r = $urandom_range(4, 7); end
                default: begin g = $urandom_range(0, 3); r = $urandom_range(0, 3); end
            endcase
            op(1'($urandom), 3'($urandom), $urandom, $urandom, g, r, $urandom, ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(negedge clk);
        chk("res_queue_empty", res_q.size(), 32'd0);
        chk("bus_queue_empty", bus_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
